// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions.
//   REG_W        : architectural register index width
//   instr_type_e : decoded instruction format codes driven on instr_type
package rv_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [2:0] {
    T_R = 3'd0,
    T_I = 3'd1,
    T_S = 3'd2,
    T_B = 3'd3,
    T_U = 3'd4,
    T_J = 3'd5,
    T_N = 3'd7
  } instr_type_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Forwarding selector for one source operand.
//   rs          : source register index
//   rf_data     : register-file read data for rs
//   fwd_valid   : per-source "holds a register-writing instruction"
//   fwd_pending : per-source "result not yet available"
//   fwd_rd      : packed destination indices, REG_W bits per source
//   fwd_data    : packed results, XLEN bits per source
//   value       : resolved operand value (0 for x0)
//   pending     : the winning source has no result yet
module operand_fwd_mux
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NFWD = 2
) (
  input  logic [REG_W-1:0]      rs,
  input  logic [XLEN-1:0]       rf_data,
  input  logic [NFWD-1:0]       fwd_valid,
  input  logic [NFWD-1:0]       fwd_pending,
  input  logic [REG_W*NFWD-1:0] fwd_rd,
  input  logic [XLEN*NFWD-1:0]  fwd_data,
  output logic [XLEN-1:0]       value,
  output logic                  pending
);

  logic found;

  // Index 0 is the youngest source; the first match found in ascending
  // order wins.
  always_comb begin
    value   = rf_data;
    pending = 1'b0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NFWD; i++) begin
      if (!found && fwd_valid[i] && (fwd_rd[i*REG_W +: REG_W] == rs)) begin
        found   = 1'b1;
        pending = fwd_pending[i];
        value   = fwd_data[i*XLEN +: XLEN];
      end
    end
    // x0 is hardwired zero and never waits on a producer.
    if (rs == '0) begin
      value   = '0;
      pending = 1'b0;
    end
  end

endmodule

// File: rtl/operand_stage.sv
// Registered operand-build stage between decode/regfile read and the ALU.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : input handshake (in_ready is combinational)
//   rs1, rs2              : source indices (rs2 doubles as shamt)
//   rs1_data, rs2_data    : register-file read data
//   pc, imm, instr_type   : instruction fields
//   shamt_used            : R-type shift-immediate
//   fwd_valid/pending/rd/data : forwarding sources, index 0 youngest
//   flush                 : kill held and incoming instruction
//   out_valid / out_ready : output handshake
//   a, b, store_data      : registered ALU operands and store data
//   out_type              : registered instr_type
//   stall_cnt             : saturating count of hazard cycles
module operand_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NFWD  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_W-1:0]      rs1,
  input  logic [REG_W-1:0]      rs2,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [XLEN-1:0]       pc,
  input  logic [XLEN-1:0]       imm,
  input  logic [2:0]            instr_type,
  input  logic                  shamt_used,
  input  logic [NFWD-1:0]       fwd_valid,
  input  logic [NFWD-1:0]       fwd_pending,
  input  logic [REG_W*NFWD-1:0] fwd_rd,
  input  logic [XLEN*NFWD-1:0]  fwd_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       a,
  output logic [XLEN-1:0]       b,
  output logic [XLEN-1:0]       store_data,
  output logic [2:0]            out_type,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic [XLEN-1:0] r1, r2;
  logic            pend1, pend2;
  logic            use1, use2;
  logic            hazard;
  logic            accept;
  logic [XLEN-1:0] nxt_a, nxt_b, nxt_sd;
  logic [XLEN-1:0] shamt_ext;

  operand_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs1 (
    .rs          (rs1),
    .rf_data     (rs1_data),
    .fwd_valid   (fwd_valid),
    .fwd_pending (fwd_pending),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .value       (r1),
    .pending     (pend1)
  );

  operand_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_rs2 (
    .rs          (rs2),
    .rf_data     (rs2_data),
    .fwd_valid   (fwd_valid),
    .fwd_pending (fwd_pending),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .value       (r2),
    .pending     (pend2)
  );

  assign shamt_ext = {{(XLEN-REG_W){1'b0}}, rs2};

  always_comb begin
    use1   = 1'b0;
    use2   = 1'b0;
    nxt_a  = '0;
    nxt_b  = '0;
    nxt_sd = '0;
    case (instr_type)
      T_R: begin
        use1  = 1'b1;
        use2  = !shamt_used;
        nxt_a = r1;
        nxt_b = shamt_used ? shamt_ext : r2;
      end
      T_I: begin
        use1  = 1'b1;
        nxt_a = r1;
        nxt_b = imm;
      end
      T_S: begin
        use1   = 1'b1;
        use2   = 1'b1;
        nxt_a  = r1;
        nxt_b  = imm;
        nxt_sd = r2;
      end
      T_B: begin
        use1  = 1'b1;
        use2  = 1'b1;
        nxt_a = r1;
        nxt_b = r2;
      end
      T_U: begin
        nxt_a = imm;
      end
      T_J: begin
        nxt_a = pc;
        nxt_b = imm;
      end
      default: ;
    endcase
  end

  // A pending producer only matters for operands the instruction reads.
  assign hazard   = (use1 && pend1) || (use2 && pend2);
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      a          <= '0;
      b          <= '0;
      store_data <= '0;
      out_type   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      a          <= nxt_a;
      b          <= nxt_b;
      store_data <= nxt_sd;
      out_type   <= instr_type;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid && hazard && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
